// File: rtl/multi_rect_object.sv
// multi_rect_object: N-channel rectangle renderer for the VGA object path.
// Two-stage pipeline: stage 1 runs a per-channel hit test and stage 2 does a
// priority encode plus output registers. Lowest enabled, visible index wins.
// Also provides a per-frame blink counter and a sticky per-frame collision
// detector, which flags any pixel that two or more objects cover.
// Optional feature: define MULTI_RECT_BORDER_EN to draw only a BORDER_W wide
// frame around each rectangle. Interior pixels then become transparent and
// never collide. With the macro undefined, each rectangle is filled.
module multi_rect_object #(
    parameter int                 N_OBJ        = 4,
    parameter int                 OBJ_WIDTH_X  = 11,
    parameter int                 OBJ_HEIGHT_Y = 48,
    parameter logic [8*N_OBJ-1:0] OBJ_COLORS   = {N_OBJ{8'h5b}},
    parameter int                 BLINK_PERIOD = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic                 startOfFrame,
    input  logic [11*N_OBJ-1:0]  topLeftX,
    input  logic [11*N_OBJ-1:0]  topLeftY,
    input  logic [N_OBJ-1:0]     objEnable,
    input  logic [N_OBJ-1:0]     blinkMask,
    output logic [10:0]          offsetX,
    output logic [10:0]          offsetY,
    output logic                 drawingRequest,
    output logic [7:0]           RGBout,
    output logic [2:0]           hitIndex,
    output logic                 collision,
    output logic [N_OBJ-1:0]     collisionMask
);

    localparam int                  CNT_W    = $clog2(BLINK_PERIOD);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BLINK_PERIOD - 1);
    localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(BLINK_PERIOD / 2);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(32'd1);
    localparam logic signed [11:0]  SPAN_X   = 12'(OBJ_WIDTH_X);
    localparam logic signed [11:0]  SPAN_Y   = 12'(OBJ_HEIGHT_Y);

    // Collision detector states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    // Number of set bits in a channel vector (N_OBJ <= 8 fits in 4 bits)
    function automatic logic [3:0] popcount(input logic [N_OBJ-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < N_OBJ; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Blink frame counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] frame_cnt_r;
    logic [CNT_W-1:0] frame_cnt_next_s;
    logic [CNT_W-1:0] frame_cnt_eff_s;

    // Next frame count, and the count that applies to the current pixel.
    // The pixel that arrives with startOfFrame already belongs to the new frame.
    always_comb begin
        frame_cnt_next_s = frame_cnt_r;
        frame_cnt_eff_s  = frame_cnt_r;
        if (frame_cnt_r == CNT_LAST) begin
            frame_cnt_next_s = {CNT_W{1'b0}};
        end else begin
            frame_cnt_next_s = frame_cnt_r + CNT_ONE;
        end
        if (startOfFrame) begin
            frame_cnt_eff_s = frame_cnt_next_s;
        end else begin
            frame_cnt_eff_s = frame_cnt_r;
        end
    end

    // Advance the frame counter once per frame
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= {CNT_W{1'b0}};
        end else if (startOfFrame) begin
            frame_cnt_r <= frame_cnt_next_s;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-channel hit test (12-bit signed compare)
    // ------------------------------------------------------------------
    logic signed [11:0] px_s;
    logic signed [11:0] py_s;
    logic               blink_on_s;
    logic [N_OBJ-1:0]   hit_s;

    assign px_s       = signed'({1'b0, pixelX});
    assign py_s       = signed'({1'b0, pixelY});
    assign blink_on_s = (frame_cnt_eff_s < CNT_HALF);

`ifdef MULTI_RECT_BORDER_EN
    localparam int                 BORDER_W = 2;
    localparam logic signed [11:0] BORDER_S = 12'(BORDER_W);
`endif

    for (genvar g = 0; g < N_OBJ; g++) begin : g_hit
        logic signed [11:0] tlx_s;
        logic signed [11:0] tly_s;
        logic signed [11:0] rx_s;
        logic signed [11:0] by_s;
        logic               in_x_s;
        logic               in_y_s;
        logic               shape_s;
        logic               visible_s;

        assign tlx_s     = signed'({topLeftX[11*g+10], topLeftX[11*g +: 11]});
        assign tly_s     = signed'({topLeftY[11*g+10], topLeftY[11*g +: 11]});
        assign rx_s      = tlx_s + SPAN_X;
        assign by_s      = tly_s + SPAN_Y;
        assign in_x_s    = (px_s >= tlx_s) && (px_s < rx_s);
        assign in_y_s    = (py_s >= tly_s) && (py_s < by_s);
        assign visible_s = ~blinkMask[g] | blink_on_s;
`ifdef MULTI_RECT_BORDER_EN
        assign shape_s   = in_x_s & in_y_s &
                           ((px_s < tlx_s + BORDER_S) | (px_s >= rx_s - BORDER_S) |
                            (py_s < tly_s + BORDER_S) | (py_s >= by_s - BORDER_S));
`else
        assign shape_s   = in_x_s & in_y_s;
`endif
        assign hit_s[g]  = objEnable[g] & visible_s & shape_s;
    end

    logic [N_OBJ-1:0]    hit_s1_r;
    logic [10:0]         px_s1_r;
    logic [10:0]         py_s1_r;
    logic [11*N_OBJ-1:0] tlx_s1_r;
    logic [11*N_OBJ-1:0] tly_s1_r;
    logic                valid_s1_r;
    logic                sof_s1_r;

    // Stage 1 pipeline register: hit vector, pixel, corners and frame marker
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_s1_r   <= {N_OBJ{1'b0}};
            px_s1_r    <= 11'd0;
            py_s1_r    <= 11'd0;
            tlx_s1_r   <= {(11*N_OBJ){1'b0}};
            tly_s1_r   <= {(11*N_OBJ){1'b0}};
            valid_s1_r <= 1'b0;
            sof_s1_r   <= 1'b0;
        end else begin
            hit_s1_r   <= hit_s;
            px_s1_r    <= pixelX;
            py_s1_r    <= pixelY;
            tlx_s1_r   <= topLeftX;
            tly_s1_r   <= topLeftY;
            valid_s1_r <= 1'b1;
            sof_s1_r   <= startOfFrame;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority encode and output registers
    // ------------------------------------------------------------------
    logic [N_OBJ-1:0] hit_eff_s;
    logic             win_found_s;
    logic [2:0]       win_idx_s;
    logic [7:0]       win_rgb_s;
    logic [10:0]      win_tlx_s;
    logic [10:0]      win_tly_s;

    assign hit_eff_s = valid_s1_r ? hit_s1_r : {N_OBJ{1'b0}};

    // Pick the lowest-index hit. The scan runs downward so the lowest index is written last.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        win_rgb_s   = 8'hFF;
        win_tlx_s   = 11'd0;
        win_tly_s   = 11'd0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (hit_eff_s[i]) begin
                win_found_s = 1'b1;
                win_idx_s   = 3'(i);
                win_rgb_s   = OBJ_COLORS[8*i +: 8];
                win_tlx_s   = tlx_s1_r[11*i +: 11];
                win_tly_s   = tly_s1_r[11*i +: 11];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Register the drawing outputs; offsets are 11-bit wrapping differences
    always_ff @(posedge clk) begin
        if (reset) begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'hFF;
            offsetX        <= 11'd0;
            offsetY        <= 11'd0;
            hitIndex       <= 3'd0;
        end else if (win_found_s) begin
            drawingRequest <= 1'b1;
            RGBout         <= win_rgb_s;
            offsetX        <= px_s1_r - win_tlx_s;
            offsetY        <= py_s1_r - win_tly_s;
            hitIndex       <= win_idx_s;
        end else begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'hFF;
            offsetX        <= 11'd0;
            offsetY        <= 11'd0;
            hitIndex       <= 3'd0;
        end
    end

    // ------------------------------------------------------------------
    // Collision detector
    // ------------------------------------------------------------------
    logic [0:0]       coll_state_r;
    logic             armed_now_s;
    logic             multi_s;
    logic [N_OBJ-1:0] det_mask_s;

    // The frame marker delayed by one stage aligns with stage 2. The pixel
    // that arrives with it is the first pixel the detector evaluates.
    assign armed_now_s = (coll_state_r == ST_ARMED) | sof_s1_r;
    assign multi_s     = (popcount(hit_eff_s) >= 4'd2);
    assign det_mask_s  = (armed_now_s & multi_s) ? hit_eff_s : {N_OBJ{1'b0}};

    // Arm on the first frame after reset; sticky flags clear at each frame, then take this pixel's detection
    always_ff @(posedge clk) begin
        if (reset) begin
            coll_state_r  <= ST_IDLE;
            collision     <= 1'b0;
            collisionMask <= {N_OBJ{1'b0}};
        end else begin
            case (coll_state_r)
                ST_IDLE: begin
                    if (sof_s1_r) begin
                        coll_state_r <= ST_ARMED;
                    end else begin
                        coll_state_r <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    coll_state_r <= ST_ARMED;
                end
                default: begin
                    coll_state_r <= ST_IDLE;
                end
            endcase
            if (sof_s1_r) begin
                collision     <= |det_mask_s;
                collisionMask <= det_mask_s;
            end else begin
                collision     <= collision | (|det_mask_s);
                collisionMask <= collisionMask | det_mask_s;
            end
        end
    end

endmodule

// File: tb/tb_multi_rect_object.sv
// Self-checking bench for multi_rect_object: table-driven hit-test vectors
// plus hand-written sequences for collision, blink and mid-frame reset.
module tb_multi_rect_object;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [43:0] topLeftX;
    logic [43:0] topLeftY;
    logic [3:0]  objEnable;
    logic [3:0]  blinkMask;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [2:0]  hitIndex;
    logic        collision;
    logic [3:0]  collisionMask;

    int checks   = 0;
    int failures = 0;

    multi_rect_object #(
        .N_OBJ        (4),
        .OBJ_WIDTH_X  (11),
        .OBJ_HEIGHT_Y (48),
        .OBJ_COLORS   ({8'h03, 8'he0, 8'h1c, 8'h5b}),
        .BLINK_PERIOD (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .startOfFrame   (startOfFrame),
        .topLeftX       (topLeftX),
        .topLeftY       (topLeftY),
        .objEnable      (objEnable),
        .blinkMask      (blinkMask),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .hitIndex       (hitIndex),
        .collision      (collision),
        .collisionMask  (collisionMask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic [3:0]  en;
        logic        dr;
        logic [7:0]  rgb;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [2:0]  idx;
        logic        coll;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic dr, input logic [7:0] rgb,
                              input logic [10:0] ox, input logic [10:0] oy, input logic [2:0] idx,
                              input logic coll, input logic [3:0] mask);
        check({name, ".drawingRequest"}, 32'(drawingRequest), 32'(dr));
        check({name, ".RGBout"},         32'(RGBout),         32'(rgb));
        check({name, ".offsetX"},        32'(offsetX),        32'(ox));
        check({name, ".offsetY"},        32'(offsetY),        32'(oy));
        check({name, ".hitIndex"},       32'(hitIndex),       32'(idx));
        check({name, ".collision"},      32'(collision),      32'(coll));
        check({name, ".collisionMask"},  32'(collisionMask),  32'(mask));
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic set_pix(input logic [10:0] x, input logic [10:0] y);
        @(negedge clk);
        pixelX = x;
        pixelY = y;
    endtask

    initial begin
        // ch0 (100,50)  ch1 (-5,200)  ch2 (105,60)  ch3 (300,300); size 11x48
        vecs[0]  = '{11'd100, 11'd50,  4'b0111, 1'b1, 8'h5b, 11'd0,  11'd0,  3'd0, 1'b0, 4'b0000};
        vecs[1]  = '{11'd111, 11'd50,  4'b0111, 1'b0, 8'hFF, 11'd0,  11'd0,  3'd0, 1'b0, 4'b0000};
        vecs[2]  = '{11'd100, 11'd98,  4'b0111, 1'b0, 8'hFF, 11'd0,  11'd0,  3'd0, 1'b0, 4'b0000};
        vecs[3]  = '{11'd99,  11'd50,  4'b0111, 1'b0, 8'hFF, 11'd0,  11'd0,  3'd0, 1'b0, 4'b0000};
        vecs[4]  = '{11'd100, 11'd49,  4'b0111, 1'b0, 8'hFF, 11'd0,  11'd0,  3'd0, 1'b0, 4'b0000};
        vecs[5]  = '{11'd110, 11'd97,  4'b0111, 1'b1, 8'h5b, 11'd10, 11'd47, 3'd0, 1'b0, 4'b0000};
        vecs[6]  = '{11'd0,   11'd210, 4'b0111, 1'b1, 8'h1c, 11'd5,  11'd10, 3'd1, 1'b0, 4'b0000};
        vecs[7]  = '{11'd6,   11'd200, 4'b0111, 1'b0, 8'hFF, 11'd0,  11'd0,  3'd0, 1'b0, 4'b0000};
        vecs[8]  = '{11'd112, 11'd107, 4'b0111, 1'b1, 8'he0, 11'd7,  11'd47, 3'd2, 1'b0, 4'b0000};
        vecs[9]  = '{11'd305, 11'd310, 4'b0111, 1'b0, 8'hFF, 11'd0,  11'd0,  3'd0, 1'b0, 4'b0000};
        vecs[10] = '{11'd305, 11'd310, 4'b1111, 1'b1, 8'h03, 11'd5,  11'd10, 3'd3, 1'b0, 4'b0000};
        vecs[11] = '{11'd100, 11'd50,  4'b0000, 1'b0, 8'hFF, 11'd0,  11'd0,  3'd0, 1'b0, 4'b0000};

        reset        = 1'b1;
        pixelX       = 11'd0;
        pixelY       = 11'd0;
        startOfFrame = 1'b0;
        topLeftX     = {11'd300, 11'd105, 11'h7FB, 11'd100};
        topLeftY     = {11'd300, 11'd60,  11'd200, 11'd50};
        objEnable    = 4'b0000;
        blinkMask    = 4'b0000;

        wait_n(2);
        check_outs("reset", 1'b0, 8'hFF, 11'd0, 11'd0, 3'd0, 1'b0, 4'b0000);
        @(negedge clk);
        reset = 1'b0;

        // Table: the collision detector is still disarmed (no frame start yet)
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pixelX    = vecs[i].px;
            pixelY    = vecs[i].py;
            objEnable = vecs[i].en;
            wait_n(2);
            check_outs($sformatf("vec%0d", i), vecs[i].dr, vecs[i].rgb, vecs[i].ox,
                       vecs[i].oy, vecs[i].idx, vecs[i].coll, vecs[i].mask);
        end

        // Collision after arming, stickiness, frame clear and its latency
        @(negedge clk);
        pixelX    = 11'd600;
        pixelY    = 11'd400;
        objEnable = 4'b0111;
        pulse_sof();
        set_pix(11'd106, 11'd61);
        wait_n(2);
        check_outs("overlap", 1'b1, 8'h5b, 11'd6, 11'd11, 3'd0, 1'b1, 4'b0101);
        set_pix(11'd600, 11'd400);
        wait_n(3);
        check_outs("sticky", 1'b0, 8'hFF, 11'd0, 11'd0, 3'd0, 1'b1, 4'b0101);
        @(negedge clk);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        check("sof_lat1.collision", 32'(collision), 32'd1);
        @(negedge clk);
        startOfFrame = 1'b0;
        @(posedge clk);
        #1;
        check("sof_lat2.collision", 32'(collision), 32'd0);
        check("sof_lat2.collisionMask", 32'(collisionMask), 32'd0);

        // Clear and set in the same cycle: only this pixel's detection remains
        set_pix(11'd106, 11'd61);
        wait_n(3);
        check_outs("overlap2", 1'b1, 8'h5b, 11'd6, 11'd11, 3'd0, 1'b1, 4'b0101);
        @(negedge clk);
        topLeftX[33 +: 11] = 11'd110;
        topLeftY[33 +: 11] = 11'd70;
        objEnable    = 4'b1111;
        pixelX       = 11'd112;
        pixelY       = 11'd75;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(posedge clk);
        #1;
        check_outs("clrset", 1'b1, 8'he0, 11'd7, 11'd15, 3'd2, 1'b1, 4'b1100);

        // Blink with BLINK_PERIOD=4: ch0 visible in frames 0,1 of each cycle
        @(negedge clk);
        reset     = 1'b1;
        blinkMask = 4'b0001;
        objEnable = 4'b0001;
        pixelX    = 11'd100;
        pixelY    = 11'd50;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_n(3);
            check($sformatf("blink%0d.drawingRequest", k), 32'(drawingRequest),
                  ((k % 4) < 2) ? 32'd1 : 32'd0);
            check($sformatf("blink%0d.RGBout", k), 32'(RGBout),
                  ((k % 4) < 2) ? 32'h5b : 32'hFF);
            pulse_sof();
        end
        pulse_sof();
        pulse_sof();
        @(negedge clk);
        objEnable = 4'b0101;
        pixelX    = 11'd106;
        pixelY    = 11'd61;
        wait_n(3);
        check_outs("blink_hidden", 1'b1, 8'he0, 11'd1, 11'd1, 3'd2, 1'b0, 4'b0000);

        // Reset mid-frame during a hit, then collision disarmed until the next frame
        @(negedge clk);
        blinkMask = 4'b0000;
        wait_n(3);
        check_outs("pre_reset", 1'b1, 8'h5b, 11'd6, 11'd11, 3'd0, 1'b1, 4'b0101);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outs("mid_reset", 1'b0, 8'hFF, 11'd0, 11'd0, 3'd0, 1'b0, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        wait_n(3);
        check_outs("disarmed", 1'b1, 8'h5b, 11'd6, 11'd11, 3'd0, 1'b0, 4'b0000);
        pulse_sof();
        wait_n(3);
        check_outs("rearmed", 1'b1, 8'h5b, 11'd6, 11'd11, 3'd0, 1'b1, 4'b0101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
